// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, access sizing, kill decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_responder_pkg;

  // RV32 load/store size and sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Widest branch mask the kill decode accepts; callers zero-extend into it
  localparam int unsigned MAX_BRM  = 8;
  localparam int unsigned MAX_KILL = 2 ** MAX_BRM;

  // Legal load pipeline depths
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  function automatic logic latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  // A request dies when the kill vector has the bit its branch mask selects
  function automatic logic killf(input logic [MAX_BRM-1:0] brmask,
                                 input logic [MAX_KILL-1:0] kill);
    return kill[brmask];
  endfunction

  // Unknown load encodings behave as a word load
  function automatic size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      F3_LW:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  // Unknown store encodings behave as a word store
  function automatic size_e store_size(input logic [2:0] f3);
    case (f3)
      F3_SB:   return SZ_B;
      F3_SH:   return SZ_H;
      F3_SW:   return SZ_W;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dff_reg.sv
// Generic enabled register with asynchronous active-low clear.
// Latency: 1 cycle from i_d to o_q when i_en is high.
// Backpressure: none; i_en low holds the current value.
module dff_reg #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load new value only when enabled, otherwise hold
  always_comb begin
    data_d = i_en ? i_d : data_q;
  end

  // State register, cleared by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign o_q = data_q;

endmodule

// File: rtl/dmem_responder_load_ext.sv
// Selects the addressed byte/half from a memory word, extends it and flags misalignment.
// Latency: combinational.
// Backpressure: none.
module dmem_responder_load_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [31:0] shifted;

  // Right-align the addressed lane, extend per funct3, zero the data on a misaligned access
  always_comb begin
    shifted = i_word >> {i_off, 3'b000};
    o_err   = misaligned(load_size(i_funct3), i_off);
    case (i_funct3)
      F3_LB:   o_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  o_data = {24'h0, shifted[7:0]};
      F3_LH:   o_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  o_data = {16'h0, shifted[15:0]};
      default: o_data = shifted;
    endcase
    if (o_err) o_data = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-array memory, stores in the accept cycle, loads returned through a kill-aware pipe.
// Latency: load response exactly LATENCY cycles after accept; stores are silent.
// Backpressure: none; ready is constant high out of reset and responses cannot be stalled.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH_MEM = 4,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 4,
  parameter int LATENCY   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_val,
  output logic                    o_req_rdy,
  input  logic                    i_req_we,
  input  logic [2:0]              i_req_funct3,
  input  logic [WIDTH_MEM-1:0]    i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [WIDTH_REG-1:0]    i_req_rd,
  input  logic [WIDTH_BRM-1:0]    i_req_brmask,
  input  logic [2**WIDTH_BRM-1:0] i_brkill,
  output logic                    o_rsp_val,
  output logic [WIDTH_REG-1:0]    o_rsp_rd,
  output logic [31:0]             o_rsp_data,
  output logic                    o_rsp_err
);

  localparam int MEM_BYTES = 2 ** WIDTH_MEM;
  localparam int KILL_W    = 2 ** WIDTH_BRM;

  if (!latency_ok(LATENCY) || (WIDTH_BRM > int'(MAX_BRM)) || (WIDTH_MEM < 2)) begin : g_param_chk
    $error("dmem_responder: illegal parameter set");
  end

  typedef struct packed {
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_BRM-1:0] brmask;
    logic [31:0]          data;
    logic                 err;
  } pay_t;

  function automatic logic br_hit(input logic [WIDTH_BRM-1:0] b, input logic [KILL_W-1:0] kill);
    return killf(MAX_BRM'(b), MAX_KILL'(kill));
  endfunction

  logic                 rdy_q, rdy_d;
  logic [7:0]           mem_q [MEM_BYTES];
  logic [7:0]           mem_d [MEM_BYTES];
  logic                 acc, req_kill, st_mis, ld_fire, st_fire;
  logic [WIDTH_MEM-3:0] word_idx;
  logic [31:0]          rd_word, st_lanes, ext_data;
  logic [3:0]           st_be;
  logic                 ext_err;
  logic                 val_d [1:LATENCY];
  logic                 val_q [1:LATENCY];
  pay_t                 pay_d [1:LATENCY];
  pay_t                 pay_q [1:LATENCY];

  // Ready comes up on the first edge after reset release and stays up
  always_comb begin
    rdy_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_q <= 1'b0;
    else          rdy_q <= rdy_d;
  end

  // Request decode: accept/kill qualification, word read and store byte lanes
  always_comb begin
    acc      = i_req_val & rdy_q;
    req_kill = br_hit(i_req_brmask, i_brkill);
    st_mis   = misaligned(store_size(i_req_funct3), i_req_addr[1:0]);
    ld_fire  = acc & ~i_req_we & ~req_kill;
    st_fire  = acc & i_req_we & ~req_kill & ~st_mis;
    word_idx = i_req_addr[WIDTH_MEM-1:2];
    rd_word  = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem_q[{word_idx, 2'(i)}];
    end
    case (store_size(i_req_funct3))
      SZ_B:    st_be = 4'b0001 << i_req_addr[1:0];
      SZ_H:    st_be = 4'b0011 << i_req_addr[1:0];
      default: st_be = 4'b1111;
    endcase
    st_lanes = i_req_wdata << {i_req_addr[1:0], 3'b000};
  end

  // Memory next state: only the addressed bytes of a live, aligned store change
  always_comb begin
    mem_d = mem_q;
    if (st_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_d[{word_idx, 2'(i)}] = st_lanes[8*i +: 8];
      end
    end
  end

  // Memory array is deliberately outside reset so contents survive it
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  dmem_responder_load_ext u_load_ext (
    .i_word   (rd_word),
    .i_off    (i_req_addr[1:0]),
    .i_funct3 (i_req_funct3),
    .o_data   (ext_data),
    .o_err    (ext_err)
  );

  // Pipe advance: stage 1 takes the new load, later stages shift and drop killed entries
  always_comb begin
    val_d[1] = ld_fire;
    pay_d[1] = '{rd: i_req_rd, brmask: i_req_brmask, data: ext_data, err: ext_err};
    for (int k = 2; k <= LATENCY; k++) begin
      val_d[k] = val_q[k-1] & ~br_hit(pay_q[k-1].brmask, i_brkill);
      pay_d[k] = pay_q[k-1];
    end
  end

  // Payload only loads under a valid entry so idle stages keep their last contents
  for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
    dff_reg #(.WIDTH(1)) u_val (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (1'b1),
      .i_d     (val_d[k]),
      .o_q     (val_q[k])
    );
    dff_reg #(.WIDTH($bits(pay_t))) u_pay (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (val_d[k]),
      .i_d     (pay_d[k]),
      .o_q     (pay_q[k])
    );
  end

  assign o_req_rdy  = rdy_q;
  assign o_rsp_val  = val_q[LATENCY];
  assign o_rsp_rd   = pay_q[LATENCY].rd;
  assign o_rsp_data = pay_q[LATENCY].data;
  assign o_rsp_err  = pay_q[LATENCY].err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases then randomized traffic against a byte-array model.
// Latency: expects every surviving load exactly L cycles after its accept cycle.
// Backpressure: none; ready must be high whenever a request is driven.
module tb_dmem_responder;

  localparam int L  = 2;
  localparam int MB = 16;
  localparam int KW = 16;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_val;
  logic        o_req_rdy;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [3:0]  i_req_addr;
  logic [31:0] i_req_wdata;
  logic [4:0]  i_req_rd;
  logic [3:0]  i_req_brmask;
  logic [15:0] i_brkill;
  logic        o_rsp_val;
  logic [4:0]  o_rsp_rd;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  dmem_responder #(.WIDTH_MEM(4), .WIDTH_REG(5), .WIDTH_BRM(4), .LATENCY(L)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_val    (i_req_val),
    .o_req_rdy    (o_req_rdy),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_rd     (i_req_rd),
    .i_req_brmask (i_req_brmask),
    .i_brkill     (i_brkill),
    .o_rsp_val    (o_rsp_val),
    .o_rsp_rd     (o_rsp_rd),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_err    (o_rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [3:0]  brmask;
    bit          killed;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl_mem [MB];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit hit(input logic [3:0] bm, input logic [15:0] kill);
    return ((KW'(1) << bm) & kill) != 0;
  endfunction

  // Reference load: gather little-endian bytes, then sign-extend from the access width
  function automatic void mdl_load(input logic [2:0] f3, input int addr,
                                   output logic [31:0] d, output logic e);
    int sz;
    bit sgn;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sgn = (f3 == 3'd0 || f3 == 3'd1);
    e   = (addr % sz) != 0;
    d   = 32'h0;
    if (!e) begin
      for (int i = 0; i < sz; i++) d = d | (32'(mdl_mem[(addr + i) % MB]) << (8 * i));
      if (sgn && d[8*sz-1]) d = d | ~((32'd1 << (8 * sz)) - 32'd1);
    end
  endfunction

  function automatic void mdl_store(input logic [2:0] f3, input int addr, input logic [31:0] wd);
    int sz;
    sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if ((addr % sz) == 0)
      for (int i = 0; i < sz; i++) mdl_mem[(addr + i) % MB] = wd[8*i +: 8];
  endfunction

  // Drive one cycle of stimulus and update the model as of that accept cycle
  task automatic drive(input bit v, input bit we, input logic [2:0] f3, input int addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [3:0] bm,
                       input logic [15:0] kill);
    logic [31:0] d;
    logic        e;
    i_req_val    = v;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr[3:0];
    i_req_wdata  = wd;
    i_req_rd     = rd;
    i_req_brmask = bm;
    i_brkill     = kill;
    if (v) chk("req_rdy", 32'(o_req_rdy), 32'd1);
    foreach (sb[i])
      if (!sb[i].killed && cyc <= sb[i].acc + L - 1 && hit(sb[i].brmask, kill)) sb[i].killed = 1;
    if (v && !hit(bm, kill)) begin
      if (we) mdl_store(f3, addr, wd);
      else begin
        mdl_load(f3, addr, d, e);
        sb.push_back('{acc: cyc, due: cyc + L, rd: rd, data: d, err: e, brmask: bm, killed: 0});
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 3'd0, 0, 32'h0, 5'd0, 4'd0, 16'h0);
  endtask

  // Monitor: pop the scoreboard whenever a response is presented or one is overdue
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      while (sb.size() > 0 && sb[0].killed && sb[0].due <= cyc) void'(sb.pop_front());
      if (o_rsp_val) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(o_rsp_rd), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          chk("rsp_rd", 32'(o_rsp_rd), 32'(e.rd));
          chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
          chk("rsp_data", o_rsp_data, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 32'(o_rsp_val), 32'd1);
      end
    end
  end

  initial begin
    int live;
    i_rst_n = 1'b0;
    i_req_val = 0; i_req_we = 0; i_req_funct3 = 0; i_req_addr = 0;
    i_req_wdata = 0; i_req_rd = 0; i_req_brmask = 0; i_brkill = 0;
    #2;
    chk("reset_rsp_val", 32'(o_rsp_val), 32'd0);
    chk("reset_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("reset_rsp_rd", 32'(o_rsp_rd), 32'd0);
    chk("reset_rsp_data", o_rsp_data, 32'd0);
    chk("reset_req_rdy", 32'(o_req_rdy), 32'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    #1 chk("rdy_before_edge", 32'(o_req_rdy), 32'd0);
    @(posedge i_clk);
    #1 chk("rdy_after_release", 32'(o_req_rdy), 32'd1);

    // Give every byte a known value
    for (int a = 0; a < MB; a += 4) drive(1, 1, 3'd2, a, $urandom, 5'd0, 4'd0, 16'h0);

    // Store then load back-to-back, plus extension cases
    drive(1, 1, 3'd2, 4, 32'hDEAD_BEEF, 5'd0, 4'd0, 16'h0);
    drive(1, 0, 3'd2, 4, 32'h0, 5'd5, 4'd0, 16'h0);
    drive(1, 1, 3'd0, 9, 32'h0000_0080, 5'd0, 4'd0, 16'h0);
    drive(1, 0, 3'd0, 9, 32'h0, 5'd6, 4'd0, 16'h0);
    drive(1, 0, 3'd4, 9, 32'h0, 5'd7, 4'd0, 16'h0);
    drive(1, 1, 3'd2, 8, 32'h1234_ABCD, 5'd0, 4'd0, 16'h0);
    drive(1, 0, 3'd1, 8, 32'h0, 5'd8, 4'd0, 16'h0);
    drive(1, 0, 3'd5, 8, 32'h0, 5'd9, 4'd0, 16'h0);
    drive(1, 0, 3'd3, 8, 32'h0, 5'd10, 4'd0, 16'h0);

    // In-flight kill of one load while an unrelated load is accepted
    drive(1, 0, 3'd2, 4, 32'h0, 5'd11, 4'd2, 16'h0);
    drive(1, 0, 3'd2, 0, 32'h0, 5'd12, 4'd1, 16'h0004);

    // Killed store leaves memory untouched
    drive(1, 1, 3'd2, 0, 32'h1111_1111, 5'd0, 4'd3, 16'h0008);
    drive(1, 0, 3'd2, 0, 32'h0, 5'd13, 4'd0, 16'h0);

    // Misaligned load and store
    drive(1, 0, 3'd2, 2, 32'h0, 5'd14, 4'd0, 16'h0);
    drive(1, 0, 3'd1, 7, 32'h0, 5'd15, 4'd0, 16'h0);
    drive(1, 1, 3'd1, 3, 32'h0000_FFFF, 5'd0, 4'd0, 16'h0);
    drive(1, 0, 3'd2, 0, 32'h0, 5'd16, 4'd0, 16'h0);
    drive(1, 0, 3'd2, 4, 32'h0, 5'd17, 4'd0, 16'h0);
    idle(L + 1);

    // Reset with a load sitting in stage 1
    drive(1, 0, 3'd2, 4, 32'h0, 5'd18, 4'd0, 16'h0);
    i_req_val = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midreset_rsp_val", 32'(o_rsp_val), 32'd0);
    chk("midreset_req_rdy", 32'(o_req_rdy), 32'd0);
    chk("midreset_rsp_data", o_rsp_data, 32'd0);
    sb.delete();
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1 chk("rdy_after_midreset", 32'(o_req_rdy), 32'd1);
    idle(L + 1);
    drive(1, 0, 3'd2, 4, 32'h0, 5'd19, 4'd0, 16'h0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [2:0]  f3;
      logic [15:0] kill;
      int          addr, sz;
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, MB - 1);
      sz   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % sz);
      kill = 16'h0;
      if ($urandom_range(0, 5) == 0)
        kill = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'd1 << $urandom_range(0, 15));
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, f3, addr, $urandom,
            5'($urandom), 4'($urandom), kill);
    end

    idle(L + 2);
    live = 0;
    foreach (sb[i]) if (!sb[i].killed) live++;
    chk("scoreboard_drained", 32'(live), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
